layer_out_serializer: RTL

//  Converts the parallel output vector of one Layer (NUM_NEURON words plus a valid pulse)

---
 rtl/layer_out_serializer_pkg.sv | 12 +
 rtl/layer_out_serializer.sv | 135 +++++++++++++
 2 files changed

// File: rtl/layer_out_serializer_pkg.sv
// Shared types and defaults for the layer output serializer.
package layer_out_serializer_pkg;

    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_NUM_NEURON = 30;

    typedef enum logic {
        IDLE = 1'b0,
        SEND = 1'b1
    } ser_state_e;

endpackage

// File: rtl/layer_out_serializer.sv
// Parallel layer vector to word-serial stream with one pending slot and sticky overflow.
// Optional ready/valid handshake on the output when SER_BACKPRESSURE_EN is defined.
module layer_out_serializer
    import layer_out_serializer_pkg::*;
#(
    parameter int NUM_NEURON = DEFAULT_NUM_NEURON,
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic                             clk,
    input  logic                             rst,
    input  logic                             i_valid,
    input  logic [NUM_NEURON*DATA_WIDTH-1:0] i_data,
`ifdef SER_BACKPRESSURE_EN
    input  logic                             o_ready,
`endif
    output logic [DATA_WIDTH-1:0]            o_data,
    output logic                             o_valid,
    output logic                             o_last,
    output logic                             o_busy,
    output logic                             o_overflow
);

    localparam int VW = NUM_NEURON * DATA_WIDTH;
    localparam int CW = $clog2(NUM_NEURON + 1);
    localparam logic [CW-1:0] LAST_IDX = CW'(NUM_NEURON - 1);

    ser_state_e            state, state_n;
    logic [VW-1:0]         shreg, shreg_n;
    logic [VW-1:0]         pend, pend_n;
    logic                  pend_valid, pend_valid_n;
    logic [CW-1:0]         count, count_n;
    logic [DATA_WIDTH-1:0] o_data_n;
    logic                  o_valid_n, o_last_n, o_overflow_n;
    logic                  load, last_issue;

`ifdef SER_BACKPRESSURE_EN
    assign load = !o_valid || o_ready;
`else
    assign load = 1'b1;
`endif

    assign last_issue = (state == SEND) && load && (count == LAST_IDX);
    assign o_busy     = (state == SEND) || pend_valid;

    always_comb begin
        state_n      = state;
        shreg_n      = shreg;
        pend_n       = pend;
        pend_valid_n = pend_valid;
        count_n      = count;
        o_data_n     = o_data;
        o_valid_n    = o_valid;
        o_last_n     = o_last;
        o_overflow_n = o_overflow;

        case (state)
            IDLE: begin
`ifdef SER_BACKPRESSURE_EN
                if (o_ready) begin
                    o_valid_n = 1'b0;
                    o_last_n  = 1'b0;
                end
`else
                o_valid_n = 1'b0;
                o_last_n  = 1'b0;
`endif
                if (i_valid) begin
                    shreg_n = i_data;
                    count_n = '0;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (load) begin
                    o_data_n  = shreg[DATA_WIDTH-1:0];
                    o_valid_n = 1'b1;
                    o_last_n  = (count == LAST_IDX);
                    shreg_n   = shreg >> DATA_WIDTH;
                    count_n   = count + CW'(1);
                end
                // On the final word, chain straight into the next vector so there is no bubble.
                if (last_issue) begin
                    if (pend_valid) begin
                        shreg_n      = pend;
                        count_n      = '0;
                        pend_valid_n = i_valid;
                        if (i_valid) begin
                            pend_n = i_data;
                        end
                    end else if (i_valid) begin
                        shreg_n = i_data;
                        count_n = '0;
                    end else begin
                        state_n = IDLE;
                    end
                end else if (i_valid) begin
                    if (!pend_valid) begin
                        pend_n       = i_data;
                        pend_valid_n = 1'b1;
                    end else begin
                        o_overflow_n = 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            count      <= '0;
            pend_valid <= 1'b0;
            o_data     <= '0;
            o_valid    <= 1'b0;
            o_last     <= 1'b0;
            o_overflow <= 1'b0;
        end else begin
            state      <= state_n;
            count      <= count_n;
            pend_valid <= pend_valid_n;
            o_data     <= o_data_n;
            o_valid    <= o_valid_n;
            o_last     <= o_last_n;
            o_overflow <= o_overflow_n;
        end
    end

    // Vector storage is qualified by state/pend_valid, so it needs no reset.
    always_ff @(posedge clk) begin
        shreg <= shreg_n;
        pend  <= pend_n;
    end

endmodule
